// File: rtl/tmu_pkg.sv
// Shared defaults and the channel-index width helper for the multi-channel engine front end.
package tmu_pkg;

  localparam int unsigned NCH_DEF     = 4;
  localparam int unsigned DW_DEF      = 12;
  localparam int unsigned ENG_LAT_DEF = 8;
  localparam int unsigned NCH_MAX     = 16;

  // Width of a channel index; a single channel still gets one bit so ports stay legal.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IDX_W_DEF = ch_idx_w(NCH_DEF);
  localparam int unsigned IDX_W_MAX = ch_idx_w(NCH_MAX);

endpackage

// File: rtl/tmu_rr_arb.sv
// Round-robin arbiter: grants the first requester after the last granted index.
module tmu_rr_arb
  import tmu_pkg::*;
#(
  parameter  int unsigned N  = NCH_DEF,
  localparam int unsigned IW = ch_idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] gnt_idx_c,
  output logic          gnt_vld_c
);

  logic [IW-1:0] last_q;
  logic [IW-1:0] cand;

  // Scan from last+1 upward, wrapping, and take the first request seen.
  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    gnt_vld_c = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(last_q) + k) % N);
      if (!gnt_vld_c && req[cand]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = cand;
      end
    end
    if (gnt_vld_c) begin
      gnt_c = N'(1) << gnt_idx_c;
    end
  end

  // Pointer starts at the top channel so channel 0 wins first after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IW'(N - 1);
    end else if (gnt_vld_c) begin
      last_q <= gnt_idx_c;
    end
  end

endmodule

// File: rtl/tmu_mchan.sv
// Multi-channel front end sharing one fixed-latency engine: per-channel holding
// registers, round-robin issue, tag pipeline and per-channel result registers.
module tmu_mchan
  import tmu_pkg::*;
#(
  parameter int unsigned NCH     = NCH_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned ENG_LAT = ENG_LAT_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NCH-1:0]    wr_en,
  input  logic [NCH*DW-1:0] wr_data,
  input  logic              ovr_clr,
  output logic              eng_req,
  output logic [DW-1:0]     eng_data,
  input  logic [DW-1:0]     eng_res,
  output logic [NCH*DW-1:0] res_data,
  output logic [NCH-1:0]    res_valid,
  output logic [NCH-1:0]    pending,
  output logic [NCH-1:0]    overrun
);

  localparam int unsigned IW = ch_idx_w(NCH);

  logic [DW-1:0]      hold_q [NCH];
  logic [NCH-1:0]     pending_q;
  logic [NCH-1:0]     overrun_q;
  logic [NCH-1:0]     pending_nxt_c;
  logic [NCH-1:0]     ovr_new_c;

  logic [NCH-1:0]     gnt_c;
  logic [IW-1:0]      gnt_idx_c;
  logic               gnt_vld_c;

  logic [IW-1:0]      eng_ch_q;
  logic [ENG_LAT-1:0] tag_vld_q;
  logic [IW-1:0]      tag_ch_q [ENG_LAT];
  logic [DW-1:0]      res_q [NCH];

  tmu_rr_arb #(.N(NCH)) u_arb (
    .clk       (clk),
    .rst       (rstn),
    .req       (pending_q),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c),
    .gnt_vld_c (gnt_vld_c)
  );

  // A write landing on its own grant refills the slot cleanly; otherwise it clobbers an unissued sample.
  always_comb begin
    ovr_new_c     = wr_en & pending_q & ~gnt_c;
    pending_nxt_c = (pending_q & ~gnt_c) | wr_en;
  end

  // Holding registers, pending and sticky overrun flags; a fresh overrun beats ovr_clr.
  always_ff @(posedge clk) begin
    if (rstn) begin
      pending_q <= '0;
      overrun_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_nxt_c;
      overrun_q <= (ovr_clr ? '0 : overrun_q) | ovr_new_c;
      for (int i = 0; i < NCH; i++) begin
        if (wr_en[i]) begin
          hold_q[i] <= wr_data[i*DW +: DW];
        end
      end
    end
  end

  // Registered issue to the engine; operand forced to zero on idle cycles.
  always_ff @(posedge clk) begin
    if (rstn) begin
      eng_req  <= 1'b0;
      eng_data <= '0;
      eng_ch_q <= '0;
    end else begin
      eng_req  <= gnt_vld_c;
      eng_data <= gnt_vld_c ? hold_q[gnt_idx_c] : '0;
      eng_ch_q <= gnt_vld_c ? gnt_idx_c : '0;
    end
  end

  // Tag pipeline: the last stage lines up with the cycle the engine result is valid.
  always_ff @(posedge clk) begin
    if (rstn) begin
      tag_vld_q <= '0;
      for (int k = 0; k < ENG_LAT; k++) begin
        tag_ch_q[k] <= '0;
      end
    end else begin
      tag_vld_q[0] <= eng_req;
      tag_ch_q[0]  <= eng_ch_q;
      for (int k = 1; k < ENG_LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_ch_q[k]  <= tag_ch_q[k-1];
      end
    end
  end

  // Capture the engine result into the tagged channel and pulse its valid for one cycle.
  always_ff @(posedge clk) begin
    if (rstn) begin
      res_valid <= '0;
      for (int i = 0; i < NCH; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      res_valid <= '0;
      if (tag_vld_q[ENG_LAT-1]) begin
        res_valid[tag_ch_q[ENG_LAT-1]] <= 1'b1;
        res_q[tag_ch_q[ENG_LAT-1]]     <= eng_res;
      end
    end
  end

  // Flatten per-channel result registers onto the output bus.
  for (genvar g = 0; g < NCH; g++) begin : g_res
    assign res_data[g*DW +: DW] = res_q[g];
  end

  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_tmu_mchan.sv
// Bench for tmu_mchan: directed scenarios plus a randomized run against a
// transaction-level model (pending set, round-robin pick, in-flight result queue).
module tb_tmu_mchan;

  localparam int unsigned NCH     = 4;
  localparam int unsigned DW      = 12;
  localparam int unsigned ENG_LAT = 8;
  localparam logic [DW-1:0] XK    = 12'h188;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NCH-1:0]    wr_en;
  logic [NCH*DW-1:0] wr_data;
  logic              ovr_clr;
  logic              eng_req;
  logic [DW-1:0]     eng_data;
  logic [DW-1:0]     eng_res;
  logic [NCH*DW-1:0] res_data;
  logic [NCH-1:0]    res_valid;
  logic [NCH-1:0]    pending;
  logic [NCH-1:0]    overrun;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  tmu_mchan #(.NCH(NCH), .DW(DW), .ENG_LAT(ENG_LAT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .ovr_clr   (ovr_clr),
    .eng_req   (eng_req),
    .eng_data  (eng_data),
    .eng_res   (eng_res),
    .res_data  (res_data),
    .res_valid (res_valid),
    .pending   (pending),
    .overrun   (overrun)
  );

  // Engine model: result = operand ^ XK, valid ENG_LAT cycles after the request; garbage otherwise.
  logic [DW-1:0] epipe [ENG_LAT];
  always @(posedge clk) begin
    epipe[0] <= eng_req ? (eng_data ^ XK) : DW'($urandom);
    for (int k = 1; k < ENG_LAT; k++) epipe[k] <= epipe[k-1];
  end
  assign eng_res = epipe[ENG_LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [NCH-1:0] we, input logic [NCH*DW-1:0] wd, input logic clr);
    wr_en   = we;
    wr_data = wd;
    ovr_clr = clr;
  endtask

  function automatic logic [DW-1:0] rd(input int i);
    return res_data[i*DW +: DW];
  endfunction

  task automatic do_reset();
    set_in('0, '0, 1'b0);
    rstn = 1'b1;
    step();
    step();
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    ntests++;
    if ({eng_req, eng_data, res_valid, res_data, pending, overrun} !== '0) begin
      nfail++;
      $display("FAIL reset_outputs got req=%b data=%h rv=%b rd=%h pend=%b ovr=%b exp all zero",
               eng_req, eng_data, res_valid, res_data, pending, overrun);
    end
    step();
    ntests++;
    if ({eng_req, eng_data, res_valid, pending, overrun} !== '0) begin
      nfail++;
      $display("FAIL reset_idle got req=%b data=%h rv=%b pend=%b ovr=%b exp all zero",
               eng_req, eng_data, res_valid, pending, overrun);
    end
  endtask

  task automatic test_single();
    int bad;
    do_reset();
    set_in(4'b0100, {12'h0, 12'h123, 24'h0}, 1'b0);
    step();
    ntests++;
    if (pending !== 4'b0100) begin
      nfail++; $display("FAIL single_pending got=%b exp=0100", pending);
    end
    set_in('0, '0, 1'b0);
    step();
    ntests++;
    if ({eng_req, eng_data, pending} !== {1'b1, 12'h123, 4'b0000}) begin
      nfail++; $display("FAIL single_issue got req=%b data=%h pend=%b exp req=1 data=123 pend=0000",
                        eng_req, eng_data, pending);
    end
    bad = 0;
    for (int k = 3; k <= 10; k++) begin
      step();
      if (res_valid !== '0 || eng_req !== 1'b0) bad++;
    end
    ntests++;
    if (bad != 0) begin
      nfail++; $display("FAIL single_quiet got %0d noisy cycles exp 0", bad);
    end
    step();
    ntests++;
    if (res_valid !== 4'b0100 || rd(2) !== 12'h0AB) begin
      nfail++; $display("FAIL single_result got rv=%b rd2=%h exp rv=0100 rd2=0ab", res_valid, rd(2));
    end
    step();
    ntests++;
    if (res_valid !== 4'b0000 || rd(2) !== 12'h0AB) begin
      nfail++; $display("FAIL single_hold got rv=%b rd2=%h exp rv=0000 rd2=0ab", res_valid, rd(2));
    end
  endtask

  task automatic test_burst();
    logic [DW-1:0] d;
    do_reset();
    set_in(4'hF, {12'h103, 12'h102, 12'h101, 12'h100}, 1'b0);
    step();
    ntests++;
    if (pending !== 4'hF) begin
      nfail++; $display("FAIL burst_pending got=%b exp=1111", pending);
    end
    set_in('0, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      d = DW'(12'h100 + k);
      ntests++;
      if ({eng_req, eng_data} !== {1'b1, d}) begin
        nfail++; $display("FAIL burst_issue%0d got req=%b data=%h exp req=1 data=%h", k, eng_req, eng_data, d);
      end
    end
    repeat (5) step();
    for (int k = 0; k < 4; k++) begin
      step();
      d = DW'(12'h100 + k) ^ XK;
      ntests++;
      if (res_valid !== NCH'(1 << k) || rd(k) !== d) begin
        nfail++; $display("FAIL burst_result%0d got rv=%b rd=%h exp rv=%b rd=%h",
                          k, res_valid, rd(k), NCH'(1 << k), d);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    set_in(4'b0011, {24'h0, 12'h010, 12'h001}, 1'b0);
    step();
    set_in(4'b0011, {24'h0, 12'h020, 12'h002}, 1'b0);
    step();
    set_in('0, '0, 1'b0);
    ntests++;
    if (overrun !== 4'b0010 || pending !== 4'b0011) begin
      nfail++; $display("FAIL ovr_flag got ovr=%b pend=%b exp ovr=0010 pend=0011", overrun, pending);
    end
    ntests++;
    if ({eng_req, eng_data} !== {1'b1, 12'h001}) begin
      nfail++; $display("FAIL ovr_issue0 got req=%b data=%h exp req=1 data=001", eng_req, eng_data);
    end
    step();
    ntests++;
    if ({eng_req, eng_data} !== {1'b1, 12'h020}) begin
      nfail++; $display("FAIL ovr_issue1 got req=%b data=%h exp req=1 data=020", eng_req, eng_data);
    end
    step();
    ntests++;
    if ({eng_req, eng_data} !== {1'b1, 12'h002}) begin
      nfail++; $display("FAIL ovr_issue2 got req=%b data=%h exp req=1 data=002", eng_req, eng_data);
    end
    step();
    ntests++;
    if (eng_req !== 1'b0 || pending !== 4'b0000) begin
      nfail++; $display("FAIL ovr_drain got req=%b pend=%b exp req=0 pend=0000", eng_req, pending);
    end
    repeat (7) step();
    ntests++;
    if (res_valid !== 4'b0010 || rd(1) !== (12'h020 ^ XK)) begin
      nfail++; $display("FAIL ovr_result got rv=%b rd1=%h exp rv=0010 rd1=%h", res_valid, rd(1), 12'h020 ^ XK);
    end
  endtask

  task automatic test_ovr_clr();
    do_reset();
    set_in(4'hF, {12'h303, 12'h302, 12'h301, 12'h300}, 1'b0);
    step();
    set_in(4'b0110, {12'h0, 12'h312, 12'h311, 12'h0}, 1'b0);
    step();
    ntests++;
    if (overrun !== 4'b0110) begin
      nfail++; $display("FAIL clr_setup got=%b exp=0110", overrun);
    end
    set_in(4'b1000, {12'h333, 36'h0}, 1'b1);
    step();
    ntests++;
    if (overrun !== 4'b1000) begin
      nfail++; $display("FAIL clr_race got=%b exp=1000", overrun);
    end
    set_in('0, '0, 1'b0);
    step();
    ntests++;
    if (overrun !== 4'b1000) begin
      nfail++; $display("FAIL clr_sticky got=%b exp=1000", overrun);
    end
    set_in('0, '0, 1'b1);
    step();
    ntests++;
    if (overrun !== 4'b0000) begin
      nfail++; $display("FAIL clr_plain got=%b exp=0000", overrun);
    end
    set_in('0, '0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    set_in(4'b0100, {12'h0, 12'h155, 24'h0}, 1'b0);
    step();
    set_in('0, '0, 1'b0);
    step();
    ntests++;
    if (eng_req !== 1'b1) begin
      nfail++; $display("FAIL rmid_issue got req=%b exp 1", eng_req);
    end
    step();
    step();
    step();
    rstn = 1'b1;
    set_in(4'b0001, {36'h0, 12'h777}, 1'b0);
    step();
    rstn = 1'b0;
    set_in('0, '0, 1'b0);
    ntests++;
    if ({eng_req, eng_data, res_valid, res_data, pending, overrun} !== '0) begin
      nfail++;
      $display("FAIL rmid_zero got req=%b data=%h rv=%b rd=%h pend=%b ovr=%b exp all zero",
               eng_req, eng_data, res_valid, res_data, pending, overrun);
    end
    bad = 0;
    repeat (14) begin
      step();
      if (res_valid !== '0 || eng_req !== 1'b0) bad++;
    end
    ntests++;
    if (bad != 0) begin
      nfail++; $display("FAIL rmid_quiet got %0d cycles with activity exp 0", bad);
    end
  endtask

  task automatic test_collision();
    do_reset();
    set_in(4'b0001, {36'h0, 12'h0A0}, 1'b0);
    step();
    set_in(4'b0001, {36'h0, 12'h0B0}, 1'b0);
    step();
    set_in('0, '0, 1'b0);
    ntests++;
    if (pending[0] !== 1'b1 || overrun[0] !== 1'b0 || eng_data !== 12'h0A0) begin
      nfail++; $display("FAIL coll_keep got pend0=%b ovr0=%b data=%h exp pend0=1 ovr0=0 data=0a0",
                        pending[0], overrun[0], eng_data);
    end
    step();
    ntests++;
    if ({eng_req, eng_data, pending} !== {1'b1, 12'h0B0, 4'b0000}) begin
      nfail++; $display("FAIL coll_second got req=%b data=%h pend=%b exp req=1 data=0b0 pend=0000",
                        eng_req, eng_data, pending);
    end
  endtask

  typedef struct {
    int            ch;
    logic [DW-1:0] val;
    int            due;
  } inflight_t;

  task automatic test_random();
    logic [DW-1:0]     m_hold [NCH];
    logic [DW-1:0]     m_res  [NCH];
    logic [NCH-1:0]    m_pend, m_ovr, m_rv, nov, we;
    logic [NCH*DW-1:0] wd, exp_rd;
    logic              m_req, clr;
    logic [DW-1:0]     m_data;
    inflight_t         q[$];
    int                m_last, g, t;

    do_reset();
    for (int i = 0; i < NCH; i++) begin
      m_hold[i] = '0;
      m_res[i]  = '0;
    end
    m_pend = '0; m_ovr = '0; m_rv = '0; m_req = 1'b0; m_data = '0;
    m_last = NCH - 1;
    t = 0;

    for (int n = 0; n < 600; n++) begin
      if ((n / 100) % 2 == 0) we = NCH'($urandom & $urandom);
      else                    we = NCH'($urandom | $urandom);
      for (int i = 0; i < NCH; i++) wd[i*DW +: DW] = DW'($urandom);
      clr = ($urandom_range(0, 9) == 0);
      set_in(we, wd, clr);

      g = -1;
      for (int k = 1; k <= NCH; k++) begin
        if (g < 0 && m_pend[(m_last + k) % NCH]) g = (m_last + k) % NCH;
      end
      m_req  = (g >= 0);
      m_data = (g >= 0) ? m_hold[g] : '0;
      nov = '0;
      for (int i = 0; i < NCH; i++) begin
        if (we[i] && m_pend[i] && i != g) nov[i] = 1'b1;
      end
      m_ovr = (clr ? '0 : m_ovr) | nov;
      if (g >= 0) begin
        q.push_back('{g, m_hold[g] ^ XK, t + int'(ENG_LAT) + 2});
        m_pend[g] = 1'b0;
        m_last = g;
      end
      m_pend = m_pend | we;
      for (int i = 0; i < NCH; i++) if (we[i]) m_hold[i] = wd[i*DW +: DW];
      t++;
      m_rv = '0;
      if (q.size() > 0 && q[0].due == t) begin
        m_rv[q[0].ch]  = 1'b1;
        m_res[q[0].ch] = q[0].val;
        void'(q.pop_front());
      end
      for (int i = 0; i < NCH; i++) exp_rd[i*DW +: DW] = m_res[i];

      step();
      ntests++;
      if ({eng_req, eng_data} !== {m_req, m_data}) begin
        nfail++; $display("FAIL rnd_issue t=%0d got req=%b data=%h exp req=%b data=%h",
                          t, eng_req, eng_data, m_req, m_data);
      end
      ntests++;
      if (pending !== m_pend || overrun !== m_ovr) begin
        nfail++; $display("FAIL rnd_flags t=%0d got pend=%b ovr=%b exp pend=%b ovr=%b",
                          t, pending, overrun, m_pend, m_ovr);
      end
      ntests++;
      if (res_valid !== m_rv || res_data !== exp_rd) begin
        nfail++; $display("FAIL rnd_result t=%0d got rv=%b rd=%h exp rv=%b rd=%h",
                          t, res_valid, res_data, m_rv, exp_rd);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rstn = 1'b1;
    set_in('0, '0, 1'b0);
    test_reset();
    test_single();
    test_burst();
    test_overrun();
    test_ovr_clr();
    test_reset_mid();
    test_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
